// File: rtl/lenet_ctrl_pkg.sv
// ============================================================================
//  lenet_ctrl_pkg
//  Shared FSM state type and default LeNet frame geometry constants.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package lenet_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_COLS     = 32;
    localparam int DEF_ROWS     = 32;
    localparam int DEF_K        = 5;
    localparam int DEF_PIPE_LAT = 4;
    localparam int DEF_AW       = 10;

    localparam int C1_LEN = DEF_COLS - DEF_K + 1;
    localparam int S2_LEN = C1_LEN / 2;

endpackage

`default_nettype wire

// File: rtl/valid_delay_line.sv
// ============================================================================
//  valid_delay_line
//  WIDTH x DEPTH shift register; advances only when adv is high.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module valid_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (adv) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/frame_sequencer.sv
// ============================================================================
//  frame_sequencer
//  Raster-order ROM walker with C1 window / S2 pool strobes and start/done.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module frame_sequencer
    import lenet_ctrl_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int K        = DEF_K,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int AW       = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    output logic [AW-1:0] rom_addr,
    output logic          rom_rd,
    output logic          c1_en,
    output logic          s2_en,
    output logic          busy,
    output logic          done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = $clog2(PIPE_LAT + 1);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(ROWS * COLS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] WIN_ROW    = RW'(K - 1);
    localparam logic [CW-1:0] WIN_COL    = CW'(K - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
    // Parity of (x - (K-1)) equals x[0] xor parity of K-1.
    localparam logic          KM1_ODD    = ((K - 1) % 2) == 1;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [RW-1:0] row_q,   row_d;
    logic [CW-1:0] col_q,   col_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic       active;
    logic       adv;
    logic       issue;
    logic       win;
    logic       pool;
    logic [1:0] tag_in;
    logic [1:0] tag_out;

    assign active = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign adv    = active && !stall;
    assign issue  = (state_q == ST_FEED) && !stall;
    assign win    = (row_q >= WIN_ROW) && (col_q >= WIN_COL);
    assign pool   = win && (row_q[0] ^ KM1_ODD) && (col_q[0] ^ KM1_ODD);
    assign tag_in = {win & issue, pool & issue};

    valid_delay_line #(
        .WIDTH (2),
        .DEPTH (PIPE_LAT)
    ) u_tags (
        .clk  (clk),
        .rst  (rst),
        .adv  (adv),
        .din  (tag_in),
        .dout (tag_out)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        col_d   = col_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FEED;
                    addr_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_FEED: begin
                if (!stall) begin
                    addr_d = addr_q + AW'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    // Park counters at zero rather than wrapping past the frame.
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                        addr_d  = '0;
                        row_d   = '0;
                        col_d   = '0;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_DONE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr = addr_q;
    assign rom_rd   = issue;
    assign c1_en    = tag_out[1] & adv;
    assign s2_en    = tag_out[0] & adv;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ============================================================================
//  tb_frame_sequencer
//  Scoreboard bench: default-size and small-config sequencers vs frame model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_sequencer;

    localparam int P_COLS [2] = '{32, 6};
    localparam int P_ROWS [2] = '{32, 6};
    localparam int P_K    [2] = '{5, 3};
    localparam int P_LAT  [2] = '{4, 2};

    typedef struct {
        int t;
        int v;
    } ev_t;

    logic clk = 1'b0;
    logic rst0, rst1, start0, start1, stall0, stall1;
    logic [9:0] addr0;
    logic [5:0] addr1;
    logic rd0, rd1, c10, c11, s20, s21, busy0, busy1, done0, done1;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    ev_t rdq  [2][$];
    ev_t c1q  [2][$];
    ev_t s2q  [2][$];
    int  dnq  [2][$];
    bit  stall_map [int];

    int busy_lo [2] = '{0, 0};
    int busy_hi [2] = '{-1, -1};
    int rdcnt [2] = '{0, 0};
    int c1cnt [2] = '{0, 0};
    int s2cnt [2] = '{0, 0};
    int ndone [2] = '{0, 0};
    int first_c1 [2] = '{-1, -1};
    int last_done [2] = '{-1, -1};

    frame_sequencer #(
        .COLS(32), .ROWS(32), .K(5), .PIPE_LAT(4), .AW(10)
    ) u_big (
        .clk(clk), .rst(rst0), .start(start0), .stall(stall0),
        .rom_addr(addr0), .rom_rd(rd0), .c1_en(c10), .s2_en(s20),
        .busy(busy0), .done(done0)
    );

    frame_sequencer #(
        .COLS(6), .ROWS(6), .K(3), .PIPE_LAT(2), .AW(6)
    ) u_small (
        .clk(clk), .rst(rst1), .start(start1), .stall(stall1),
        .rom_addr(addr1), .rom_rd(rd1), .c1_en(c11), .s2_en(s21),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int d, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s dut=%0d cycle=%0d got=%0d expected=%0d", name, d, cyc, got, exp);
        end
    endfunction

    function automatic void unexpected(input string name, input int d);
        total++;
        bad++;
        $display("FAIL %s dut=%0d cycle=%0d got=strobe expected=none", name, d, cyc);
    endfunction

    // Expected events for one frame, from start cycle s and the stall schedule.
    task automatic push_frame(input int d, input int s);
        int at[$];
        int t, n, cols, k, lat, r, c, ci;
        ev_t e;
        cols = P_COLS[d];
        k    = P_K[d];
        lat  = P_LAT[d];
        n    = P_ROWS[d] * cols;
        t    = s + 1;
        while (at.size() < n + lat) begin
            if (!stall_map.exists(2 * t + d)) at.push_back(t);
            t++;
        end
        for (int p = 0; p < n; p++) begin
            r = p / cols;
            c = p % cols;
            e.t = at[p];
            e.v = p;
            rdq[d].push_back(e);
            if (r >= k - 1 && c >= k - 1) begin
                ci  = (r - k + 1) * (cols - k + 1) + (c - k + 1);
                e.t = at[p + lat];
                e.v = ci;
                c1q[d].push_back(e);
                if (((r - k + 1) % 2 == 1) && ((c - k + 1) % 2 == 1)) s2q[d].push_back(e);
            end
        end
        busy_lo[d] = s + 1;
        busy_hi[d] = at[n + lat - 1] + 1;
        dnq[d].push_back(busy_hi[d]);
    endtask

    // Monitor: pops the scoreboard whenever a DUT strobe appears.
    always @(negedge clk) begin
        logic rd [2];
        logic c1 [2];
        logic s2 [2];
        logic dn [2];
        logic bz [2];
        logic rs [2];
        int   ad [2];
        ev_t  e;
        int   t;
        int   kk, cc, rr;
        rd = '{rd0, rd1};   c1 = '{c10, c11};   s2 = '{s20, s21};
        dn = '{done0, done1}; bz = '{busy0, busy1}; rs = '{rst0, rst1};
        ad = '{int'(addr0), int'(addr1)};
        for (int d = 0; d < 2; d++) begin
            if (rs[d]) begin
                rdcnt[d] = 0;
                c1cnt[d] = 0;
                s2cnt[d] = 0;
            end
            chk("busy", d, int'(bz[d]), int'(cyc >= busy_lo[d] && cyc <= busy_hi[d]));
            if (rd[d]) begin
                if (rdq[d].size() == 0) unexpected("rom_rd", d);
                else begin
                    e = rdq[d].pop_front();
                    chk("rd_cycle", d, cyc, e.t);
                    chk("rd_addr", d, ad[d], e.v);
                end
                rdcnt[d]++;
            end
            if (s2[d]) begin
                if (s2q[d].size() == 0) unexpected("s2_en", d);
                else begin
                    e = s2q[d].pop_front();
                    chk("s2_cycle", d, cyc, e.t);
                    chk("s2_c1_index", d, c1cnt[d], e.v);
                end
                s2cnt[d]++;
            end
            if (c1[d]) begin
                if (c1cnt[d] == 0) first_c1[d] = cyc;
                if (c1q[d].size() == 0) unexpected("c1_en", d);
                else begin
                    e = c1q[d].pop_front();
                    chk("c1_cycle", d, cyc, e.t);
                    chk("c1_index", d, c1cnt[d], e.v);
                end
                c1cnt[d]++;
            end
            if (dn[d]) begin
                if (dnq[d].size() == 0) unexpected("done", d);
                else begin
                    t = dnq[d].pop_front();
                    chk("done_cycle", d, cyc, t);
                end
                kk = P_K[d];
                rr = P_ROWS[d] - kk + 1;
                cc = P_COLS[d] - kk + 1;
                chk("rd_count", d, rdcnt[d], P_ROWS[d] * P_COLS[d]);
                chk("c1_count", d, c1cnt[d], rr * cc);
                chk("s2_count", d, s2cnt[d], (rr / 2) * (cc / 2));
                rdcnt[d] = 0;
                c1cnt[d] = 0;
                s2cnt[d] = 0;
                ndone[d]++;
                last_done[d] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        stall0 = stall_map.exists(2 * cyc);
        stall1 = stall_map.exists(2 * cyc + 1);
    endtask

    task automatic tick_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic launch(input int d);
        if (cyc > busy_hi[d]) push_frame(d, cyc);
        if (d == 0) start0 = 1'b1;
        else        start1 = 1'b1;
    endtask

    task automatic add_stall(input int d, input int from, input int len);
        for (int j = 0; j < len; j++) stall_map[2 * (from + j) + d] = 1'b1;
    endtask

    task automatic random_stalls(input int d, input int base, input int span);
        int st, ln;
        for (int w = 0; w < 4; w++) begin
            st = base + 2 + int'($urandom_range(0, span));
            ln = int'($urandom_range(1, 6));
            add_stall(d, st, ln);
        end
    endtask

    task automatic check_big_zero(input string name);
        chk({name, "_addr"}, 0, int'(addr0), 0);
        chk({name, "_rd"},   0, int'(rd0), 0);
        chk({name, "_c1"},   0, int'(c10), 0);
        chk({name, "_s2"},   0, int'(s20), 0);
        chk({name, "_busy"}, 0, int'(busy0), 0);
        chk({name, "_done"}, 0, int'(done0), 0);
    endtask

    int s1, s2, s4, nd;

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        stall0 = 1'b0; stall1 = 1'b0;
        #2;
        check_big_zero("reset");
        chk("reset_small_rd", 1, int'(rd1), 0);
        chk("reset_small_busy", 1, int'(busy1), 0);
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;
        tick_until(10);

        // Frame 1 plus ignored starts; small frame alongside.
        s1 = cyc;
        launch(0);
        launch(1);
        tick_until(s1 + 20); launch(1);
        tick_until(s1 + 45);
        chk("small_done_time", 1, last_done[1], s1 + 39);
        chk("small_first_c1", 1, first_c1[1], s1 + 17);
        random_stalls(1, cyc, 40);
        launch(1);
        tick_until(s1 + 50); launch(0);
        tick_until(s1 + 1029); launch(0);

        // Frame 2 with directed stalls in FEED and DRAIN.
        tick();
        s2 = cyc;
        chk("f1_done_time", 0, last_done[0], s1 + 1029);
        chk("f1_first_c1", 0, first_c1[0], s1 + 137);
        chk("f1_single_done", 0, ndone[0], 1);
        add_stall(0, s2 + 200, 10);
        add_stall(0, s2 + 1036, 3);
        launch(0);
        tick_until(s2 + 1045);
        chk("f2_done_time", 0, last_done[0], s2 + 1042);
        chk("f2_first_c1", 0, first_c1[0], s2 + 137);

        // Frame 3 with random stalls and gap.
        tick_until(cyc + int'($urandom_range(1, 20)));
        random_stalls(0, cyc, 1100);
        launch(0);
        tick_until(busy_hi[0] + 2);

        // Frame 4 aborted by reset.
        s4 = cyc;
        nd = ndone[0];
        launch(0);
        tick_until(s4 + 500);
        #1;
        rst0 = 1'b1;
        rdq[0].delete(); c1q[0].delete(); s2q[0].delete(); dnq[0].delete();
        busy_hi[0] = -1;
        #1;
        check_big_zero("midreset");
        tick(); tick();
        #1;
        rst0 = 1'b0;
        tick_until(cyc + 30);
        chk("no_done_after_reset", 0, ndone[0], nd);

        // Frame 5 after reset, random stalls.
        random_stalls(0, cyc, 1100);
        launch(0);
        tick_until(busy_hi[0] + 3);

        for (int d = 0; d < 2; d++) begin
            chk("rd_left", d, rdq[d].size(), 0);
            chk("c1_left", d, c1q[d].size(), 0);
            chk("s2_left", d, s2q[d].size(), 0);
            chk("done_left", d, dnq[d].size(), 0);
        end
        chk("frames_done", 0, ndone[0], 4);
        chk("frames_done", 1, ndone[1], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Top-level sequencer for one LeNet input frame. It walks the image ROM in raster order, tracks row and column position, and produces the C1 window-valid strobe and the S2 2x2-pool strobe, both aligned to datapath latency. It replaces free-running countdown-from-power-up enables with a start/busy/done handshake, a stall input and a clean reset, so frames can be processed back-to-back under host control. It sits between the host/testbench and the ROM plus the C1/S2 datapath.

Parameters:
COLS, 32, pixels per input row
ROWS, 32, rows per input frame
K, 5, C1 convolution kernel size (square)
PIPE_LAT, 4, cycles from ROM read issue to C1 output for that pixel position
AW, 10, ROM address width; must satisfy 2^AW >= ROWS*COLS

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to process a frame; sampled only in IDLE
stall  in  1  freezes all counters, state and delay line while high (FEED/DRAIN only)
rom_addr  out  AW  ROM pixel address, raster order
rom_rd  out  1  ROM read strobe
c1_en  out  1  C1 output valid; the K x K window ending at the aligned pixel is complete
s2_en  out  1  S2 latch strobe; the 2x2 pool window of C1 outputs is complete
busy  out  1  high from FEED entry until the DONE cycle, inclusive
done  out  1  one-cycle pulse at frame end

Behaviour:
- All outputs registered. rst asynchronously forces IDLE, rom_addr=0, row=col=0, delay line cleared, all strobes 0, busy=0, done=0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: outputs 0. start=1 -> FEED next cycle with addr=row=col=0.
- start outside IDLE is ignored. No queuing.
- FEED, stall=0: rom_rd=1 and rom_addr=current addr. Then addr+1, col+1. When col==COLS-1, col wraps to 0 and row+1.
- FEED exit: the cycle issuing addr ROWS*COLS-1 with stall=0 -> DRAIN.
- FEED, stall=1: rom_rd=0; addr, row, col and delay line hold.
- Tags computed per issued pixel:
  - win = (row>=K-1) && (col>=K-1)
  - pool = win && (row-(K-1)) odd && (col-(K-1)) odd, using the C1 output coordinates
- Both tags enter a PIPE_LAT-deep shift register that advances only on unstalled cycles. Non-issue cycles insert 0.
- c1_en/s2_en = delay line output, gated by ~stall.
- Pixel issued at unstalled cycle t -> its strobes at t+PIPE_LAT unstalled cycles.
- DRAIN: counts PIPE_LAT unstalled cycles, then DONE. The last c1_en coincides with the final DRAIN cycle.
- DONE: done=1 and busy=1 for one cycle, then IDLE. stall is ignored in DONE and IDLE.
- Per frame, default params: 1024 rom_rd, 784 c1_en (28x28), 196 s2_en (14x14).
- Counters: row/col are ceil(log2) width of ROWS/COLS. The DRAIN counter is ceil(log2(PIPE_LAT+1)) bits. No arithmetic wrap beyond the defined terminal counts.
- Reset mid-frame: immediate IDLE, no done pulse. Strobes already in the delay line are discarded.

Decomposition:
- Package lenet_ctrl_pkg: state enum (IDLE, FEED, DRAIN, DONE), default COLS/ROWS/K constants, and derived constants C1_LEN=COLS-K+1 and S2_LEN=C1_LEN/2.
- Sub-module valid_delay_line: parameterised WIDTH x DEPTH shift register with advance enable and async clear. It carries {win,pool}.
- FSM and counters stay in frame_sequencer.

Test Plan:
- Basic frame: start pulse at cycle 0 -> rom_rd cycles 1..1024 with addr 0..1023; first c1_en at cycle 137 (pixel addr 132); done at cycle 1029; counts 784 c1_en and 196 s2_en.
- Pool alignment: record the c1_en index of each s2_en -> s2_en lands on C1 outputs at odd row and odd column within the 28x28 grid, first one at C1 output (1,1) = c1_en #30.
- Stall: stall high 10 cycles from cycle 200, and 3 cycles during DRAIN -> addr/strobes frozen, all counts unchanged, done delayed by exactly 13 cycles to 1042.
- Start while busy: start pulses at cycles 50 and 1029 -> ignored both times, a single done. A start at cycle 1030 (IDLE) launches a second frame with rom_rd from 1031.
- Reset mid-frame: rst asserted at cycle 500 for 2 cycles -> all outputs 0 asynchronously, no done. A new start afterwards gives a full 1024/784/196 frame.
- Small config: ROWS=COLS=6, K=3, PIPE_LAT=2 -> 36 rom_rd, 16 c1_en, 4 s2_en, done at cycle 39 after start at 0.
